// File: rtl/alu_seq.sv
// Registered ALU core with a start/ready/done handshake.
// Single-cycle ops give one result per cycle. MUL is a fixed-latency shift-add
// multiplier that returns the full double-width product.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op_code,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam logic [2:0]     OpAdd = 3'b000;
    localparam logic [2:0]     OpSub = 3'b001;
    localparam logic [2:0]     OpAnd = 3'b010;
    localparam logic [2:0]     OpOr  = 3'b011;
    localparam logic [2:0]     OpXor = 3'b100;
    localparam logic [2:0]     OpShl = 3'b101;
    localparam logic [2:0]     OpMul = 3'b110;
    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       out_q, out_d, out_hi_q, out_hi_d;
    logic                   carry_q, carry_d, zero_q, zero_d;
    logic                   ovf_q, ovf_d, err_q, err_d, done_q, done_d;
    logic [2*WIDTH-1:0]     mcand_q, mcand_d, acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]       mplr_q, mplr_d;
    logic [SHW-1:0]         cnt_q, cnt_d;

    logic [WIDTH:0]         sum, diff, shl_ext;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_carry, alu_ovf, alu_err;

    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};
    // Extra top bit catches the last bit shifted out; stays 0 for a zero shift.
    assign shl_ext  = {1'b0, a} << b[SHW-1:0];
    assign acc_step = mplr_q[0] ? acc_q + mcand_q : acc_q;

    // Single-cycle datapath: result and flags for the presented opcode.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (op_code)
            OpAdd: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd: alu_res = a & b;
            OpOr:  alu_res = a | b;
            OpXor: alu_res = a ^ b;
            OpShl: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = shl_ext[WIDTH];
            end
            OpMul: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate the multiplier in MUL.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op_code == OpMul) begin
                        state_d = StMul;
                        mcand_d = {{WIDTH{1'b0}}, a};
                        mplr_d  = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        out_d    = alu_res;
                        out_hi_d = '0;
                        carry_d  = alu_carry;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        err_d    = alu_err;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d   = acc_step;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + SHW'(1);
                if (cnt_q == CntLast) begin
                    out_d    = acc_step[WIDTH-1:0];
                    out_hi_d = acc_step[2*WIDTH-1:WIDTH];
                    carry_d  = |acc_step[2*WIDTH-1:WIDTH];
                    zero_d   = (acc_step[WIDTH-1:0] == '0);
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= StIdle;
            out_q    <= '0;
            out_hi_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready  = (state_q == StIdle);
    assign done   = done_q;
    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance on one clock and reset.
module tb_alu_seq;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        s32;
    logic [31:0] a32, b32, o32, oh32;
    logic [2:0]  op32;
    logic        rdy32, dn32, c32, z32, v32, e32;

    // 8-bit instance
    logic        s8;
    logic [7:0]  a8, b8, o8, oh8;
    logic [2:0]  op8;
    logic        rdy8, dn8, c8, z8, v8, e8;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    int bad_ready;
    int dn_seen;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .nrst(nrst), .start(s32), .a(a32), .b(b32), .op_code(op32),
        .ready(rdy32), .done(dn32), .out(o32), .out_hi(oh32),
        .carry(c32), .zero(z32), .ovf(v32), .err(e32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .nrst(nrst), .start(s8), .a(a8), .b(b8), .op_code(op8),
        .ready(rdy8), .done(dn8), .out(o8), .out_hi(oh8),
        .carry(c8), .zero(z8), .ovf(v8), .err(e8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {done, ready, err, ovf, zero, carry}.
    function automatic logic [5:0] fl32();
        return {dn32, rdy32, e32, v32, z32, c32};
    endfunction

    function automatic logic [5:0] fl8();
        return {dn8, rdy8, e8, v8, z8, c8};
    endfunction

    task automatic go32(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        s32 = 1'b1; op32 = op; a32 = x; b32 = y;
        tick();
    endtask

    initial begin
        nrst = 1'b0;
        s32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
        s8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;

        // Reset for two edges with a start pulse that must be ignored.
        tick();
        s32 = 1'b1; op32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
        s8  = 1'b1; op8  = 3'b111;
        tick();
        check("rst32_out", {oh32, o32}, 64'h0);
        check("rst32_flags", fl32(), 6'b010000);
        check("rst8_out", {oh8, o8}, 16'h0);
        check("rst8_flags", fl8(), 6'b010000);
        s32 = 1'b0; s8 = 1'b0;
        nrst = 1'b1;
        tick(); tick(); tick();
        check("idle32_out", {oh32, o32}, 64'h0);
        check("idle32_flags", fl32(), 6'b010000);

        // ADD/SUB flag corners.
        go32(3'b000, 32'hFFFF_FFFF, 32'h1);
        check("add_wrap_out", o32, 32'h0);
        check("add_wrap_flags", fl32(), 6'b110011);
        go32(3'b000, 32'h7FFF_FFFF, 32'h1);
        check("add_ovf_out", o32, 32'h8000_0000);
        check("add_ovf_flags", fl32(), 6'b110100);
        go32(3'b001, 32'd3, 32'd5);
        check("sub_borrow_out", o32, 32'hFFFF_FFFE);
        check("sub_borrow_flags", fl32(), 6'b110001);
        s32 = 1'b0;
        tick();
        check("hold_out", o32, 32'hFFFF_FFFE);
        check("hold_flags", fl32(), 6'b010001);

        // Back-to-back single-cycle ops.
        go32(3'b000, 32'd5, 32'd6);
        check("b2b_add_out", o32, 32'd11);
        check("b2b_add_flags", fl32(), 6'b110000);
        go32(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("b2b_and_out", o32, 32'hF000_F000);
        check("b2b_and_flags", fl32(), 6'b110000);
        go32(3'b100, 32'hAAAA_5555, 32'hFFFF_0000);
        check("b2b_xor_out", o32, 32'h5555_5555);
        check("b2b_xor_flags", fl32(), 6'b110000);
        go32(3'b101, 32'h8000_0001, 32'd1);
        check("b2b_shl_out", o32, 32'h0000_0002);
        check("b2b_shl_flags", fl32(), 6'b110001);

        // Shift corners: amount taken from b[4:0], zero amount gives no carry.
        go32(3'b101, 32'h0000_000F, 32'h20);
        check("shl0_out", o32, 32'h0000_000F);
        check("shl0_flags", fl32(), 6'b110000);
        go32(3'b101, 32'h1000_0000, 32'd4);
        check("shl4_out", o32, 32'h0);
        check("shl4_flags", fl32(), 6'b110011);
        go32(3'b011, 32'h0000_00F0, 32'h0000_000F);
        check("or_out", o32, 32'h0000_00FF);

        // 32-bit MUL: latency, busy start ignored, ADD accepted in done cycle.
        go32(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        s32 = 1'b0;
        check("mul_busy_ready", rdy32, 1'b0);
        lat = 0; bad_ready = 0;
        while (!dn32 && lat < 40) begin
            tick();
            lat++;
            if (lat == 5) begin
                s32 = 1'b1; op32 = 3'b000; a32 = 32'd1; b32 = 32'd1;
            end
            if (!dn32 && rdy32) bad_ready++;
        end
        check("mul32_latency", lat, 32);
        check("mul32_ready_low", bad_ready, 0);
        check("mul32_prod", {oh32, o32}, 64'hFFFF_FFFE_0000_0001);
        check("mul32_flags", fl32(), 6'b110001);
        tick();
        s32 = 1'b0;
        check("add_after_mul_out", {oh32, o32}, 64'h2);
        check("add_after_mul_flags", fl32(), 6'b110000);

        // 8-bit instance: MUL and reserved opcode.
        s8 = 1'b1; op8 = 3'b110; a8 = 8'h0F; b8 = 8'h11;
        tick();
        s8 = 1'b0;
        lat = 0;
        while (!dn8 && lat < 20) begin
            tick();
            lat++;
        end
        check("mul8_latency", lat, 8);
        check("mul8_prod", {oh8, o8}, 16'h00FF);
        check("mul8_flags", fl8(), 6'b110000);
        s8 = 1'b1; op8 = 3'b111; a8 = 8'h55; b8 = 8'h33;
        tick();
        check("rsv8_out", {oh8, o8}, 16'h0);
        check("rsv8_flags", fl8(), 6'b111010);
        op8 = 3'b000; a8 = 8'h7F; b8 = 8'h01;
        tick();
        s8 = 1'b0;
        check("add8_ovf_out", o8, 8'h80);
        check("add8_ovf_flags", fl8(), 6'b110100);

        // Reset in the 5th MUL cycle aborts without a done pulse.
        go32(3'b110, 32'd100, 32'd3);
        s32 = 1'b0;
        tick(); tick(); tick(); tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check("abort_out", {oh32, o32}, 64'h0);
        check("abort_flags", fl32(), 6'b010000);
        dn_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dn32) dn_seen++;
        end
        check("abort_no_done", dn_seen, 0);

        go32(3'b110, 32'd6, 32'd7);
        s32 = 1'b0;
        lat = 0;
        while (!dn32 && lat < 40) begin
            tick();
            lat++;
        end
        check("mul67_latency", lat, 32);
        check("mul67_prod", {oh32, o32}, 64'd42);
        check("mul67_flags", fl32(), 6'b110000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
